// File: rtl/pr_stream_decoupler.sv
// pr_stream_decoupler
//   Isolates a partial-reconfiguration region from the shell on NUM_CH
//   AXI-Stream channel pairs. On decouple_req the block lets packets already
//   in flight finish (DRAIN), blocks new packet starts, and then gates all
//   crossing handshakes (DECOUPLED). A drain that does not finish within
//   TIMEOUT_CYCLES is forced to DECOUPLED and flagged in timeout_err.
//
// Ports
//   CLK, ARESETN                 clock, async active-low reset
//   decouple_req                 level request to isolate the region
//   decouple_ack                 high while isolated (registered)
//   draining                     high while in DRAIN
//   timeout_err                  sticky, set by a forced decouple
//   s_role_* -> m_shell_*        role-to-shell streams, channel 0 in LSBs
//   s_shell_* -> m_role_*        shell-to-role streams, channel 0 in LSBs
//
// State | meaning
// ------+-------------------------------------------------------------
// COUPLED    | all channels pass freely
// DRAIN      | only channels with an open packet pass; new starts blocked
// DECOUPLED  | every crossing tvalid/tready held low, ack asserted
module pr_stream_decoupler #(
   parameter int unsigned DATA_WIDTH     = 512,
   parameter int unsigned NUM_CH         = 2,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
   input  logic                             CLK,
   input  logic                             ARESETN,
   input  logic                             decouple_req,
   output logic                             decouple_ack,
   output logic                             draining,
   output logic                             timeout_err,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     s_role_tdata,
   input  logic [NUM_CH*DATA_WIDTH/8-1:0]   s_role_tkeep,
   input  logic [NUM_CH-1:0]                s_role_tlast,
   input  logic [NUM_CH-1:0]                s_role_tvalid,
   output logic [NUM_CH-1:0]                s_role_tready,
   output logic [NUM_CH*DATA_WIDTH-1:0]     m_shell_tdata,
   output logic [NUM_CH*DATA_WIDTH/8-1:0]   m_shell_tkeep,
   output logic [NUM_CH-1:0]                m_shell_tlast,
   output logic [NUM_CH-1:0]                m_shell_tvalid,
   input  logic [NUM_CH-1:0]                m_shell_tready,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     s_shell_tdata,
   input  logic [NUM_CH*DATA_WIDTH/8-1:0]   s_shell_tkeep,
   input  logic [NUM_CH-1:0]                s_shell_tlast,
   input  logic [NUM_CH-1:0]                s_shell_tvalid,
   output logic [NUM_CH-1:0]                s_shell_tready,
   output logic [NUM_CH*DATA_WIDTH-1:0]     m_role_tdata,
   output logic [NUM_CH*DATA_WIDTH/8-1:0]   m_role_tkeep,
   output logic [NUM_CH-1:0]                m_role_tlast,
   output logic [NUM_CH-1:0]                m_role_tvalid,
   input  logic [NUM_CH-1:0]                m_role_tready
);

   typedef enum logic [1:0] {ST_COUPLED, ST_DRAIN, ST_DECOUPLED} state_t;

   localparam logic [31:0] CNT_LAST = TIMEOUT_CYCLES - 32'd1;

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] r2s_pkt_q, r2s_pkt_d, s2r_pkt_q, s2r_pkt_d;
   logic [NUM_CH-1:0] r2s_pass, s2r_pass, r2s_next, s2r_next;
   logic [31:0]       cnt_q, cnt_d;
   logic              ack_q, ack_d, err_q, err_d;
   logic [NUM_CH-1:0] rst_mask;

   // Payload is never registered or gated; only the handshake is.
   assign m_shell_tdata = s_role_tdata;
   assign m_shell_tkeep = s_role_tkeep;
   assign m_shell_tlast = s_role_tlast;
   assign m_role_tdata  = s_shell_tdata;
   assign m_role_tkeep  = s_shell_tkeep;
   assign m_role_tlast  = s_shell_tlast;

   // Handshakes drop immediately when reset asserts, before any clock edge.
   assign rst_mask       = {NUM_CH{ARESETN}};
   assign m_shell_tvalid = s_role_tvalid  & r2s_pass & rst_mask;
   assign s_role_tready  = m_shell_tready & r2s_pass & rst_mask;
   assign m_role_tvalid  = s_shell_tvalid & s2r_pass & rst_mask;
   assign s_shell_tready = m_role_tready  & s2r_pass & rst_mask;

   assign decouple_ack = ack_q;
   assign draining     = (state_q == ST_DRAIN);
   assign timeout_err  = err_q;

   // Per-channel pass enable and the packet-open flags after this cycle's beat.
   always_comb begin
      r2s_pass = '0;
      s2r_pass = '0;
      r2s_next = r2s_pkt_q;
      s2r_next = s2r_pkt_q;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         r2s_pass[c] = (state_q == ST_COUPLED) | ((state_q == ST_DRAIN) & r2s_pkt_q[c]);
         s2r_pass[c] = (state_q == ST_COUPLED) | ((state_q == ST_DRAIN) & s2r_pkt_q[c]);
         if (s_role_tvalid[c] & m_shell_tready[c] & r2s_pass[c])
            r2s_next[c] = ~s_role_tlast[c];
         if (s_shell_tvalid[c] & m_role_tready[c] & s2r_pass[c])
            s2r_next[c] = ~s_shell_tlast[c];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      r2s_pkt_d = r2s_next;
      s2r_pkt_d = s2r_next;
      case (state_q)
         ST_COUPLED: begin
            if (decouple_req) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (cnt_q != '1)
               cnt_d = cnt_q + 32'd1;
            // Abort wins over both completion and timeout; flags are kept.
            if (!decouple_req) begin
               state_d = ST_COUPLED;
            end else if ((r2s_next == '0) && (s2r_next == '0)) begin
               state_d = ST_DECOUPLED;
            end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_q == CNT_LAST)) begin
               state_d   = ST_DECOUPLED;
               err_d     = 1'b1;
               r2s_pkt_d = '0;
               s2r_pkt_d = '0;
            end
         end
         ST_DECOUPLED: begin
            if (!decouple_req)
               state_d = ST_COUPLED;
         end
         default: state_d = ST_COUPLED;
      endcase
      // Ack tracks the next state so it rises on entry and falls on release.
      ack_d = (state_d == ST_DECOUPLED);
   end

   always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= ST_COUPLED;
         r2s_pkt_q <= '0;
         s2r_pkt_q <= '0;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         r2s_pkt_q <= r2s_pkt_d;
         s2r_pkt_q <= s2r_pkt_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

endmodule
